// File: rtl/axi_slave_rd_burst_pkg.sv
// ---------------------------------------------------------------------------
// axi_slave_rd_burst_pkg
// Shared encodings for the AXI slave read-burst controller: burst types,
// transfer sizes, read response codes and controller states, plus the
// request-legality helpers used when AXI_RD_SLVERR_EN is defined.
// No ports (package).
// ---------------------------------------------------------------------------
package axi_slave_rd_burst_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burstT;

    localparam logic [2:0] SIZE_1B = 3'b000;
    localparam logic [2:0] SIZE_2B = 3'b001;
    localparam logic [2:0] SIZE_4B = 3'b010;
    localparam logic [2:0] SIZE_8B = 3'b011;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DRAIN = 2'b10
    } stateT;

    // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
    function automatic logic isLegalWrapLen(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

    // A request this slave cannot serve from a 64-bit SRAM.
    function automatic logic arIsBad(input logic [1:0] burst,
                                     input logic [2:0] size,
                                     input logic [3:0] len);
        return (burst == BURST_RSVD) ||
               (size > SIZE_8B) ||
               ((burst == BURST_WRAP) && !isLegalWrapLen(len));
    endfunction

endpackage

// File: rtl/axi_slave_rd_burst_if.sv
// ---------------------------------------------------------------------------
// axi_slave_rd_burst_if
// AXI read address (AR) and read data (R) channel bundle.
//   master modport : drives ARVALID/ARID/ARADDR/ARLEN/ARSIZE/ARBURST, RREADY
//   slave  modport : drives ARREADY, RVALID/RID/RDATA/RRESP/RLAST
// Parameters ID_W, ADDR_W, DATA_W size the ID, address and data fields.
// ---------------------------------------------------------------------------
interface axi_slave_rd_burst_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              ARVALID;
    logic              ARREADY;
    logic [ID_W-1:0]   ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [3:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;

    logic              RVALID;
    logic              RREADY;
    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;

    modport master (
        output ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, RREADY,
        input  ARREADY, RVALID, RID, RDATA, RRESP, RLAST
    );

    modport slave (
        input  ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, RREADY,
        output ARREADY, RVALID, RID, RDATA, RRESP, RLAST
    );
endinterface

// File: rtl/EgSlaveAxiAGen.sv
// ---------------------------------------------------------------------------
// EgSlaveAxiAGen
// Combinational AXI next-beat address generator within a 4 kB window.
//   curAddr  in  12  current beat byte address
//   len      in  4   burst length minus one
//   size     in  3   log2 bytes per beat
//   burst    in  2   FIXED / INCR / WRAP (reserved treated as INCR)
//   nextAddr out 12  byte address of the following beat
// INCR aligns to the beat size and rolls over modulo 4096; WRAP stays inside
// the (len+1)*2^size aligned window.
// ---------------------------------------------------------------------------
module EgSlaveAxiAGen
    import axi_slave_rd_burst_pkg::*;
(
    input  logic [11:0] curAddr,
    input  logic [3:0]  len,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [11:0] nextAddr
);
    logic [11:0] beatBytes;
    logic [11:0] wrapBytes;
    logic [11:0] incrAddr;
    logic [11:0] wrapBase;

    always_comb begin
        beatBytes = 12'd1 << size;
        wrapBytes = beatBytes * ({8'd0, len} + 12'd1);
        // Subsequent beats of an unaligned start land on aligned addresses.
        incrAddr  = (curAddr & ~(beatBytes - 12'd1)) + beatBytes;
        wrapBase  = curAddr & ~(wrapBytes - 12'd1);
        case (burst)
            BURST_FIXED: nextAddr = curAddr;
            BURST_WRAP:  nextAddr = wrapBase | (incrAddr & (wrapBytes - 12'd1));
            default:     nextAddr = incrAddr;
        endcase
    end
endmodule

// File: rtl/axi_slave_rd_burst_out_buf.sv
// ---------------------------------------------------------------------------
// axi_rd_out_buf
// Two-entry FIFO holding packed R beats {RID, RDATA, RRESP, RLAST}.
//   clk      in   clock
//   rstN     in   asynchronous active-low reset (empties the FIFO)
//   push     in   write pushData
//   pushData in   WIDTH entry
//   pop      in   retire head entry
//   headData out  head entry; when empty, the most recently popped entry
//   count    out  occupancy 0..2 (used by the issuer for credit)
//   valid    out  occupancy != 0
// ---------------------------------------------------------------------------
module axi_rd_out_buf #(
    parameter int WIDTH = 71
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic [1:0]       count,
    output logic             valid
);
    logic [1:0][WIDTH-1:0] entries;
    logic                  wrPtr;
    logic                  rdPtr;
    logic [1:0]            countReg;
    logic                  pushOk;
    logic                  popOk;

    assign popOk  = pop && (countReg != 2'd0);
    assign pushOk = push && ((countReg != 2'd2) || popOk);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            entries  <= '0;
            wrPtr    <= 1'b0;
            rdPtr    <= 1'b0;
            countReg <= 2'd0;
        end else begin
            if (pushOk) begin
                entries[wrPtr] <= pushData;
                wrPtr          <= ~wrPtr;
            end
            if (popOk) begin
                rdPtr <= ~rdPtr;
            end
            countReg <= countReg + {1'b0, pushOk} - {1'b0, popOk};
        end
    end

    // After a pop the read pointer has moved past the retired slot, so the
    // other slot still holds the last beat shown; this keeps RDATA steady
    // while the buffer is empty.
    assign headData = (countReg != 2'd0) ? entries[rdPtr] : entries[~rdPtr];
    assign count    = countReg;
    assign valid    = (countReg != 2'd0);
endmodule

// File: rtl/axi_slave_rd_burst.sv
// ---------------------------------------------------------------------------
// axi_slave_rd_burst
// AXI read-channel burst controller in front of a 4 kB, 64-bit SRAM with
// one-cycle read latency. One AR is accepted at a time; beats are issued to
// the SRAM at most one per cycle, limited by a 2-entry output buffer credit,
// and returned on R in order.
//   ACLK       in   clock
//   ARESETn    in   asynchronous active-low reset
//   axi        slave modport of axi_slave_rd_burst_if (AR and R channels)
//   MemRd      out  SRAM read strobe
//   MemAddr    out  SRAM word address (byte address [11:3])
//   MemRdData  in   SRAM read data, valid the cycle after MemRd
// Optional: define AXI_RD_SLVERR_EN to answer reserved bursts, sizes above
// 8 bytes and illegal WRAP lengths with SLVERR beats and no SRAM access.
// ---------------------------------------------------------------------------
module axi_slave_rd_burst
    import axi_slave_rd_burst_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    axi_slave_rd_burst_if.slave axi,
    output logic                MemRd,
    output logic [8:0]          MemAddr,
    input  logic [DATA_W-1:0]   MemRdData
);
    localparam int ENTRY_W = ID_W + DATA_W + 2 + 1;

    stateT             state;
    logic              arReadyReg;
    logic [ID_W-1:0]   idReg;
    logic [11:0]       curAddr;
    logic [3:0]        lenReg;
    logic [2:0]        sizeReg;
    logic [1:0]        burstReg;
    logic [3:0]        issueCnt;
    logic [3:0]        retCnt;
    logic              inFlight;

    logic [11:0]       nextAddr;
    logic [2:0]        occupancy;
    logic              issueFire;
    logic              push;
    logic              pop;
    logic              lastPop;
    logic [DATA_W-1:0] pushData;
    logic [1:0]        pushResp;
    logic [ENTRY_W-1:0] pushEntry;
    logic [ENTRY_W-1:0] headEntry;
    logic [1:0]        bufCount;
    logic              bufValid;
    logic              unusedAddrHi;

    // Only the 4 kB window is decoded.
    assign unusedAddrHi = ^axi.ARADDR[ADDR_W-1:12];

    EgSlaveAxiAGen agen (
        .curAddr  (curAddr),
        .len      (lenReg),
        .size     (sizeReg),
        .burst    (burstReg),
        .nextAddr (nextAddr)
    );

    // Credit: buffered beats plus the read in flight, less the beat leaving
    // this cycle, must stay below the buffer depth for a new issue.
    assign pop       = bufValid && axi.RREADY;
    assign lastPop   = pop && axi.RLAST;
    assign occupancy = {1'b0, bufCount} + {2'b00, inFlight} - {2'b00, pop};
    assign issueFire = (state == ISSUE) && (occupancy < 3'd2);
    assign push      = inFlight;

`ifdef AXI_RD_SLVERR_EN
    logic errFlag;

    // Error bursts still walk the issue/credit path so beats come back at
    // the same rate, but the SRAM is never strobed and data is zeroed.
    assign MemRd    = issueFire && !errFlag;
    assign pushData = errFlag ? '0 : MemRdData;
    assign pushResp = errFlag ? RRESP_SLVERR : RRESP_OKAY;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            errFlag <= 1'b0;
        end else if ((state == IDLE) && axi.ARVALID && arReadyReg) begin
            errFlag <= arIsBad(axi.ARBURST, axi.ARSIZE, axi.ARLEN);
        end
    end
`else
    assign MemRd    = issueFire;
    assign pushData = MemRdData;
    assign pushResp = RRESP_OKAY;
`endif

    assign MemAddr = curAddr[11:3];

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state      <= IDLE;
            arReadyReg <= 1'b0;
            idReg      <= '0;
            curAddr    <= '0;
            lenReg     <= '0;
            sizeReg    <= '0;
            burstReg   <= '0;
            issueCnt   <= '0;
            retCnt     <= '0;
            inFlight   <= 1'b0;
        end else begin
            inFlight <= issueFire;
            if (push) begin
                retCnt <= retCnt - 4'd1;
            end
            case (state)
                IDLE: begin
                    arReadyReg <= 1'b1;
                    if (axi.ARVALID && arReadyReg) begin
                        idReg      <= axi.ARID;
                        curAddr    <= axi.ARADDR[11:0];
                        lenReg     <= axi.ARLEN;
                        sizeReg    <= axi.ARSIZE;
                        burstReg   <= axi.ARBURST;
                        issueCnt   <= axi.ARLEN;
                        retCnt     <= axi.ARLEN;
                        arReadyReg <= 1'b0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issueFire) begin
                        curAddr  <= nextAddr;
                        issueCnt <= issueCnt - 4'd1;
                        if (issueCnt == 4'd0) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (lastPop) begin
                        state      <= IDLE;
                        arReadyReg <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign pushEntry = {idReg, pushData, pushResp, (retCnt == 4'd0)};

    axi_rd_out_buf #(
        .WIDTH (ENTRY_W)
    ) outBuf (
        .clk      (ACLK),
        .rstN     (ARESETn),
        .push     (push),
        .pushData (pushEntry),
        .pop      (pop),
        .headData (headEntry),
        .count    (bufCount),
        .valid    (bufValid)
    );

    assign axi.ARREADY = arReadyReg;
    assign axi.RVALID  = bufValid;
    assign {axi.RID, axi.RDATA, axi.RRESP, axi.RLAST} = headEntry;
endmodule

// File: tb/tb_axi_slave_rd_burst.sv
// ---------------------------------------------------------------------------
// tb_axi_slave_rd_burst
// Directed bench for axi_slave_rd_burst. Drivers push expected SRAM word
// addresses and R beats into queues; a negedge monitor pops and compares
// whenever the DUT strobes MemRd or completes an R handshake.
// ---------------------------------------------------------------------------
module tb_axi_slave_rd_burst;
    import axi_slave_rd_burst_pkg::*;

    typedef struct {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } rBeatT;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        MemRd;
    logic [8:0]  MemAddr;
    logic [63:0] MemRdData = '0;

    int checks = 0;
    int failures = 0;

    rBeatT      rQ[$];
    logic [8:0] addrQ[$];

    int   beatsSeen = 0;
    int   issuedCnt = 0;
    int   poppedCnt = 0;
    time  arTime = 0;
    time  firstRTime = 0;
    time  firstMemTime = 0;
    time  lastPopTime = 0;
    logic armTiming = 1'b0;
    logic readyPend = 1'b0;
    logic prevStall = 1'b0;
    logic prevValid = 1'b0;
    logic [70:0] prevEntry = '0;

    axi_slave_rd_burst_if #(.ID_W(4), .ADDR_W(32), .DATA_W(64)) axi();

    axi_slave_rd_burst #(.ID_W(4), .ADDR_W(32), .DATA_W(64)) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .axi       (axi),
        .MemRd     (MemRd),
        .MemAddr   (MemAddr),
        .MemRdData (MemRdData)
    );

    always #5 ACLK = ~ACLK;

    function automatic logic [63:0] wordOf(input logic [8:0] a);
        return {32'hCAFE_0000 | {23'd0, a}, 32'h5A00_0000 | {23'd0, ~a}};
    endfunction

    // SRAM model: one-cycle read latency.
    always @(posedge ACLK) begin
        if (MemRd) MemRdData <= wordOf(MemAddr);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic expectBeat(input logic [3:0] id, input logic [8:0] a, input logic last);
        rBeatT b;
        b.id = id; b.data = wordOf(a); b.resp = RRESP_OKAY; b.last = last;
        rQ.push_back(b);
        addrQ.push_back(a);
    endtask

    task automatic expectErrBeat(input logic [3:0] id, input logic last);
        rBeatT b;
        b.id = id; b.data = '0; b.resp = RRESP_SLVERR; b.last = last;
        rQ.push_back(b);
    endtask

    // Monitor / scoreboard.
    always @(negedge ACLK) begin
        if (!ARESETn) begin
            prevStall = 1'b0;
            prevValid = 1'b0;
            readyPend = 1'b0;
            issuedCnt = 0;
            poppedCnt = 0;
        end else begin
            logic popNow;
            popNow = axi.RVALID && axi.RREADY;
            if (readyPend) begin
                chk("arready_after_last", {63'd0, axi.ARREADY}, 64'd1);
                readyPend = 1'b0;
            end
            if (prevStall) begin
                checks++;
                if (!axi.RVALID || ({axi.RID, axi.RDATA, axi.RRESP, axi.RLAST} !== prevEntry)) begin
                    failures++;
                    $display("FAIL r_stable actual valid=%0d beat=%h expected valid=1 beat=%h",
                             axi.RVALID, {axi.RID, axi.RDATA, axi.RRESP, axi.RLAST}, prevEntry);
                end
            end
            if (armTiming && axi.RVALID && !prevValid && firstRTime == 0) firstRTime = $time;
            if (MemRd) begin
                if (armTiming && firstMemTime == 0) firstMemTime = $time;
                checks++;
                if (addrQ.size() == 0) begin
                    failures++;
                    $display("FAIL mem_addr actual=unexpected MemRd addr=%h expected=no read", MemAddr);
                end else begin
                    logic [8:0] ea;
                    ea = addrQ.pop_front();
                    if (MemAddr !== ea) begin
                        failures++;
                        $display("FAIL mem_addr actual=%h expected=%h", MemAddr, ea);
                    end
                end
                chk("credit_outstanding", 64'(issuedCnt - poppedCnt - int'(popNow) < 2), 64'd1);
                issuedCnt++;
            end
            if (popNow) begin
                checks++;
                beatsSeen++;
                poppedCnt++;
                $display("R beat id=%h data=%h resp=%0d last=%0d t=%0t",
                         axi.RID, axi.RDATA, axi.RRESP, axi.RLAST, $time);
                if (rQ.size() == 0) begin
                    failures++;
                    $display("FAIL r_beat actual=unexpected beat id=%h expected=none", axi.RID);
                end else begin
                    rBeatT e;
                    e = rQ.pop_front();
                    if (axi.RID !== e.id || axi.RDATA !== e.data ||
                        axi.RRESP !== e.resp || axi.RLAST !== e.last) begin
                        failures++;
                        $display("FAIL r_beat actual id=%h data=%h resp=%0d last=%0d expected id=%h data=%h resp=%0d last=%0d",
                                 axi.RID, axi.RDATA, axi.RRESP, axi.RLAST, e.id, e.data, e.resp, e.last);
                    end
                end
                if (axi.RLAST) begin
                    lastPopTime = $time;
                    readyPend = 1'b1;
                end
            end
            prevStall = axi.RVALID && !axi.RREADY;
            prevValid = axi.RVALID;
            prevEntry = {axi.RID, axi.RDATA, axi.RRESP, axi.RLAST};
        end
    end

    task automatic sendAr(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        int n;
        @(negedge ACLK);
        axi.ARID = id; axi.ARADDR = addr; axi.ARLEN = len;
        axi.ARSIZE = size; axi.ARBURST = burst; axi.ARVALID = 1'b1;
        n = 0;
        while (!axi.ARREADY && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        if (!axi.ARREADY) begin
            checks++;
            failures++;
            $display("FAIL ar_handshake actual=ARREADY low after 50 cycles expected=accept");
            axi.ARVALID = 1'b0;
            return;
        end
        @(posedge ACLK);
        arTime = $time;
        $display("AR id=%h addr=%h len=%0d size=%0d burst=%0d t=%0t", id, addr, len, size, burst, $time);
        #1 axi.ARVALID = 1'b0;
    endtask

    task automatic waitDrain(input string name, input int bound);
        int n;
        n = 0;
        while (rQ.size() != 0 && n < bound) begin
            @(negedge ACLK);
            #1;
            n++;
        end
        chk({name, "_r_pending"}, 64'(rQ.size()), 64'd0);
        chk({name, "_addr_pending"}, 64'(addrQ.size()), 64'd0);
        rQ.delete();
        addrQ.delete();
        @(negedge ACLK);
        @(negedge ACLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        axi.ARVALID = 1'b0; axi.ARID = '0; axi.ARADDR = '0; axi.ARLEN = '0;
        axi.ARSIZE = '0; axi.ARBURST = '0; axi.RREADY = 1'b1;

        // Reset state.
        @(negedge ACLK); #1;
        chk("rst_arready", {63'd0, axi.ARREADY}, 64'd0);
        chk("rst_rvalid",  {63'd0, axi.RVALID}, 64'd0);
        chk("rst_rlast",   {63'd0, axi.RLAST}, 64'd0);
        chk("rst_rresp",   {62'd0, axi.RRESP}, 64'd0);
        chk("rst_rid",     {60'd0, axi.RID}, 64'd0);
        chk("rst_rdata",   axi.RDATA, 64'd0);
        chk("rst_memrd",   {63'd0, MemRd}, 64'd0);
        chk("rst_memaddr", {55'd0, MemAddr}, 64'd0);
        ARESETn = 1'b1;
        @(negedge ACLK); #1;
        chk("arready_after_release", {63'd0, axi.ARREADY}, 64'd1);

        // INCR 0x100, 4 beats of 8 bytes, with latency checks.
        armTiming = 1'b1; firstRTime = 0; firstMemTime = 0;
        expectBeat(4'h5, 9'h020, 1'b0);
        expectBeat(4'h5, 9'h021, 1'b0);
        expectBeat(4'h5, 9'h022, 1'b0);
        expectBeat(4'h5, 9'h023, 1'b1);
        sendAr(4'h5, 32'h0000_0100, 4'd3, SIZE_8B, BURST_INCR);
        waitDrain("incr4", 60);
        armTiming = 1'b0;
        chk("incr4_first_memrd_time", 64'(firstMemTime), 64'(arTime + 5));
        chk("incr4_first_rvalid_time", 64'(firstRTime), 64'(arTime + 25));
        chk("incr4_last_beat_time", 64'(lastPopTime), 64'(arTime + 55));

        // WRAP 0x38, 4 beats of 8 bytes; upper address bits ignored.
        expectBeat(4'h3, 9'h007, 1'b0);
        expectBeat(4'h3, 9'h004, 1'b0);
        expectBeat(4'h3, 9'h005, 1'b0);
        expectBeat(4'h3, 9'h006, 1'b1);
        sendAr(4'h3, 32'hABCD_0038, 4'd3, SIZE_8B, BURST_WRAP);
        waitDrain("wrap4", 60);

        // FIXED 0x010, 8 beats of 4 bytes, ID 0xA.
        for (int i = 0; i < 8; i++) expectBeat(4'hA, 9'h002, i == 7);
        sendAr(4'hA, 32'h0000_0010, 4'd7, SIZE_4B, BURST_FIXED);
        waitDrain("fixed8", 80);

        // INCR 16 beats with RREADY pattern 1,0,0,1.
        for (int i = 0; i < 16; i++) expectBeat(4'h7, 9'h060 + 9'(i), i == 15);
        base = beatsSeen;
        sendAr(4'h7, 32'h0000_0300, 4'd15, SIZE_8B, BURST_INCR);
        for (int k = 0; k < 200 && rQ.size() != 0; k++) begin
            axi.RREADY = (k % 4 == 0) || (k % 4 == 3);
            @(posedge ACLK);
            #1;
        end
        axi.RREADY = 1'b1;
        waitDrain("incr16_bp", 20);
        chk("incr16_beat_count", 64'(beatsSeen - base), 64'd16);

        // Reset during beat 3 of an 8-beat burst.
        for (int i = 0; i < 8; i++) expectBeat(4'h6, 9'h040 + 9'(i), i == 7);
        base = beatsSeen;
        sendAr(4'h6, 32'h0000_0200, 4'd7, SIZE_8B, BURST_INCR);
        n = 0;
        while (beatsSeen < base + 2 && n < 50) begin
            @(negedge ACLK);
            #1;
            n++;
        end
        chk("rst_mid_reached_beat3", 64'(beatsSeen - base), 64'd2);
        ARESETn = 1'b0;
        #1;
        chk("rst_mid_rvalid_drop", {63'd0, axi.RVALID}, 64'd0);
        chk("rst_mid_memrd_drop", {63'd0, MemRd}, 64'd0);
        rQ.delete();
        addrQ.delete();
        @(posedge ACLK);
        @(negedge ACLK); #1;
        chk("rst_mid_arready_low", {63'd0, axi.ARREADY}, 64'd0);
        ARESETn = 1'b1;
        @(negedge ACLK); #1;
        chk("rst_mid_arready_high", {63'd0, axi.ARREADY}, 64'd1);
        expectBeat(4'h9, 9'h01F, 1'b1);
        sendAr(4'h9, 32'h0000_00F8, 4'd0, SIZE_8B, BURST_INCR);
        waitDrain("single_after_rst", 30);

`ifdef AXI_RD_SLVERR_EN
        // Reserved burst: three SLVERR beats, no SRAM reads.
        expectErrBeat(4'h2, 1'b0);
        expectErrBeat(4'h2, 1'b0);
        expectErrBeat(4'h2, 1'b1);
        sendAr(4'h2, 32'h0000_0040, 4'd2, SIZE_8B, BURST_RSVD);
        waitDrain("slverr3", 40);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
